// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-digit display slice.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none; the PS/2 device cannot be stalled.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HELD  = 2'd1,
      ST_BREAK = 2'd2
   } key_state_e;

   localparam logic [7:0] BRK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;

   // Two-digit BCD increment {tens, ones}, wrapping 99 -> 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] lo;
      logic [3:0] hi;
      lo = v[3:0];
      hi = v[7:4];
      if (lo == 4'd9) begin
         lo = 4'd0;
         hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
      end else begin
         lo = lo + 4'd1;
      end
      return {hi, lo};
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronize, detect falling edges, shift 11-bit frames, validate, time out partial frames.
// Latency: byte_valid_o / err_o pulse 1 clk after the 11th synchronized falling edge is seen.
// Backpressure: none; byte_valid_o is a single-cycle pulse the consumer must take immediately.
module ps2_rx #(
   parameter int TIMEOUT_CYC  = 50000,
   parameter bit PARITY_CHECK = 1'b1
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       err_o
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [2:0]    clk_s_q;
   logic [2:0]    dat_s_q;
   logic [9:0]    shift_q, shift_d;
   logic [3:0]    bit_q, bit_d;
   logic [TW-1:0] idle_q, idle_d;
   logic          vld_q, vld_d;
   logic          err_q, err_d;
   logic          fall;
   logic          frame_ok;
   logic [10:0]   frame_new;

   // Three-flop synchronizers; idle PS/2 lines are high, so reset to 1.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_s_q <= 3'b111;
         dat_s_q <= 3'b111;
      end else begin
         clk_s_q <= {clk_s_q[1:0], ps2_clk};
         dat_s_q <= {dat_s_q[1:0], ps2_data};
      end
   end

   // Frame assembly, validation and mid-frame timeout.
   always_comb begin
      fall      = clk_s_q[2] & ~clk_s_q[1];
      // Bit 0 is start (oldest), bits 8:1 data, 9 parity, 10 stop (newest).
      frame_new = {dat_s_q[2], shift_q};
      frame_ok  = ~frame_new[0] & frame_new[10] &
                  (~PARITY_CHECK | (^frame_new[9:1]));
      shift_d   = shift_q;
      bit_d     = bit_q;
      idle_d    = idle_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      if (fall) begin
         shift_d = frame_new[10:1];
         idle_d  = '0;
         if (bit_q == 4'd10) begin
            bit_d = 4'd0;
            vld_d = frame_ok;
            err_d = ~frame_ok;
         end else begin
            bit_d = bit_q + 4'd1;
         end
      end else if (bit_q != 4'd0) begin
         if (idle_q == TO_LAST) begin
            bit_d  = 4'd0;
            idle_d = '0;
         end else begin
            idle_d = idle_q + TW'(1);
         end
      end
   end

   // Receiver state registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         shift_q <= '0;
         bit_q   <= '0;
         idle_q  <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         bit_q   <= bit_d;
         idle_q  <= idle_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   // After a complete frame the shift register holds frame[10:1]; data is its low byte.
   assign byte_o       = shift_q[7:0];
   assign byte_valid_o = vld_q;
   assign err_o        = err_q;

endmodule

// File: rtl/ps2_key_digits.sv
// PS/2 key display: latches the held scan code and counts key presses in 2-digit BCD.
// Latency: outputs update 1 clk after the receiver's byte_valid pulse; frame_err passes straight from the receiver.
// Backpressure: none; every delivered byte is consumed in the cycle it arrives.
module ps2_key_digits
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC  = 50000,
   parameter bit PARITY_CHECK = 1'b1
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] code_lo,
   output logic [3:0] code_hi,
   output logic       code_en,
   output logic [3:0] cnt_lo,
   output logic [3:0] cnt_hi,
   output logic       cnt_hi_en,
   output logic       frame_err
);

   logic [7:0] rx_byte;
   logic       rx_vld;
   logic       rx_err;

   key_state_e state_q, state_d;
   logic [7:0] code_q, code_d;
   logic       en_q, en_d;
   logic [7:0] cnt_q, cnt_d;

   ps2_rx #(
      .TIMEOUT_CYC  (TIMEOUT_CYC),
      .PARITY_CHECK (PARITY_CHECK)
   ) u_rx (
      .clk          (clk),
      .clrn         (clrn),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_vld),
      .err_o        (rx_err)
   );

   // Key FSM: track press / typematic repeat / release of the latched key.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      en_d    = en_q;
      cnt_d   = cnt_q;
      if (rx_vld && (rx_byte != EXT_CODE)) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte != BRK_CODE) begin
                  code_d  = rx_byte;
                  en_d    = 1'b1;
                  cnt_d   = bcd_inc(cnt_q);
                  state_d = ST_HELD;
               end
            end
            ST_HELD: begin
               if (rx_byte == BRK_CODE) begin
                  state_d = ST_BREAK;
               end else if (rx_byte != code_q) begin
                  code_d = rx_byte;
                  cnt_d  = bcd_inc(cnt_q);
               end
            end
            ST_BREAK: begin
               // Release of some other key leaves the latched key still down.
               if (rx_byte == code_q) begin
                  en_d    = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HELD;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM and display registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= ST_IDLE;
         code_q  <= '0;
         en_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
      end
   end

   assign code_hi   = code_q[7:4];
   assign code_lo   = code_q[3:0];
   assign code_en   = en_q;
   assign cnt_hi    = cnt_q[7:4];
   assign cnt_lo    = cnt_q[3:0];
   assign cnt_hi_en = (cnt_q[7:4] != 4'd0);
   assign frame_err = rx_err;

endmodule
